// File: rtl/ahb_reg_controller.sv
`default_nettype none
// ============================================================================
// Module   : ahb_reg_controller
// Brief    : AHB-Lite slave in front of the USB endpoint value registers and
//            data buffer. Decodes the address phase, answers register reads
//            with zero wait states, and waits on the buffer handshake. Illegal
//            accesses and buffer timeouts get a two-cycle ERROR response.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_reg_controller #(
   parameter int ADDR_WIDTH  = 4,
   parameter int BUF_TIMEOUT = 15
) (
   input  logic                  i_clk,
   input  logic                  i_nRst,
   input  logic                  i_hsel,
   input  logic [ADDR_WIDTH-1:0] i_haddr,
   input  logic [1:0]            i_htrans,
   input  logic [1:0]            i_hsize,
   input  logic                  i_hwrite,
   input  logic [31:0]           i_hwdata,
   output logic [31:0]           o_hrdata,
   output logic                  o_hready,
   output logic                  o_hresp,
   input  logic [15:0]           i_statusData,
   input  logic [15:0]           i_errorData,
   input  logic [7:0]            i_boData,
   input  logic [7:0]            i_ehtsData,
   output logic [7:0]            o_nextEHTSData,
   output logic                  o_clearError,
   output logic                  o_flush,
   output logic                  o_bufRead,
   output logic                  o_bufWrite,
   output logic [1:0]            o_bufSize,
   output logic [31:0]           o_bufWdata,
   input  logic [31:0]           i_bufRdata,
   input  logic                  i_bufAck
);

   // Counter holds 0..BUF_TIMEOUT-1 while waiting; the last value is the
   // final cycle in which an acknowledge is still honoured.
   localparam int c_CNT_W = (BUF_TIMEOUT < 2) ? 1 : $clog2(BUF_TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BUF_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_REG_ACC  = 3'd1,
      S_BUF_WAIT = 3'd2,
      S_ERR1     = 3'd3,
      S_ERR2     = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_next;
   state_t               w_dec;
   logic [3:0]           r_off;
   logic                 r_write;
   logic [1:0]           r_size;
   logic [c_CNT_W-1:0]   r_cnt;

   logic                 w_ready;
   logic                 w_valid;
   logic                 w_hi_zero;
   logic                 w_sel_buf;
   logic                 w_legal;
   logic [3:0]           w_off;

   // The slave stalls only in the first error cycle and while the buffer
   // has not acknowledged.
   assign w_ready  = (r_state != S_ERR1) && !((r_state == S_BUF_WAIT) && !i_bufAck);
   assign o_hready = w_ready;

   assign w_off     = i_haddr[3:0];
   assign w_hi_zero = ((i_haddr >> 4) == '0);
   assign w_sel_buf = w_hi_zero && (w_off[3:2] == 2'b00);
   assign w_valid   = i_hsel && w_ready && ((i_htrans == 2'b10) || (i_htrans == 2'b11));

   assign o_bufSize  = r_size;
   assign o_bufWdata = i_hwdata;

   // Legality of the transfer currently in its address phase.
   always_comb begin
      w_legal = 1'b0;
      if (w_hi_zero && (i_hsize != 2'b11)) begin
         case (w_off)
            4'h0, 4'h1, 4'h2, 4'h3: w_legal = 1'b1;
            4'h4, 4'h8:             w_legal = !i_hwrite;
            4'h6, 4'hC, 4'hD:       w_legal = 1'b1;
            default:                w_legal = 1'b0;
         endcase
      end
   end

   // Data-phase state chosen for the transfer in its address phase.
   always_comb begin
      w_dec = S_IDLE;
      if (w_valid) begin
         if (!w_legal)       w_dec = S_ERR1;
         else if (w_sel_buf) w_dec = S_BUF_WAIT;
         else                w_dec = S_REG_ACC;
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_nRst) begin
      if (!i_nRst) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Capture address-phase controls whenever a transfer is accepted.
   always_ff @(posedge i_clk or negedge i_nRst) begin
      if (!i_nRst) begin
         r_off   <= 4'h0;
         r_write <= 1'b0;
         r_size  <= 2'b00;
      end else if (w_valid) begin
         r_off   <= w_off;
         r_write <= i_hwrite;
         r_size  <= i_hsize;
      end
   end

   // Buffer wait counter, cleared whenever the buffer is not being waited on.
   always_ff @(posedge i_clk or negedge i_nRst) begin
      if (!i_nRst)                                   r_cnt <= '0;
      else if ((r_state == S_BUF_WAIT) && !i_bufAck) r_cnt <= r_cnt + c_CNT_W'(1);
      else                                           r_cnt <= '0;
   end

   // Next state and data-phase outputs.
   always_comb begin
      w_next         = r_state;
      o_hresp        = 1'b0;
      o_hrdata       = 32'h0;
      o_clearError   = 1'b0;
      o_flush        = 1'b0;
      o_bufRead      = 1'b0;
      o_bufWrite     = 1'b0;
      o_nextEHTSData = i_ehtsData;
      case (r_state)
         S_IDLE: w_next = w_dec;
         S_REG_ACC: begin
            w_next = w_dec;
            if (r_write) begin
               case (r_off)
                  4'h6:    o_clearError   = 1'b1;
                  4'hC:    o_nextEHTSData = i_hwdata[7:0];
                  4'hD:    o_flush        = i_hwdata[0];
                  default: o_clearError   = 1'b0;
               endcase
            end else begin
               case (r_off)
                  4'h4:    o_hrdata = {16'h0, i_statusData};
                  4'h6:    o_hrdata = {i_errorData, 16'h0};
                  4'h8:    o_hrdata = {24'h0, i_boData};
                  4'hC:    o_hrdata = {24'h0, i_ehtsData};
                  default: o_hrdata = 32'h0;
               endcase
            end
         end
         S_BUF_WAIT: begin
            if (i_bufAck) begin
               if (!r_write) o_hrdata = i_bufRdata;
               w_next = w_dec;
            end else begin
               o_bufRead  = !r_write;
               o_bufWrite = r_write;
               if (r_cnt == c_LAST) w_next = S_ERR1;
            end
         end
         S_ERR1: begin
            o_hresp = 1'b1;
            w_next  = S_ERR2;
         end
         S_ERR2: begin
            o_hresp = 1'b1;
            w_next  = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_ahb_reg_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_reg_controller
// Brief    : Directed bench for ahb_reg_controller with a transaction-level
//            reference model compared every cycle, plus literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_reg_controller;
   localparam int T = 15;
   localparam int K_REG = 0;
   localparam int K_BUF = 1;
   localparam int K_ERR = 2;

   logic        clk, nRst, hsel, hwrite, bufAck;
   logic [3:0]  haddr;
   logic [1:0]  htrans, hsize;
   logic [31:0] hwdata, bufRdata;
   logic [15:0] statusData, errorData;
   logic [7:0]  boData, ehtsData;
   logic [31:0] hrdata, bufWdata;
   logic        hready, hresp, clearError, flush, bufRead, bufWrite;
   logic [7:0]  nextEHTSData;
   logic [1:0]  bufSize;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 0;

   ahb_reg_controller #(.ADDR_WIDTH(4), .BUF_TIMEOUT(T)) dut (
      .i_clk(clk), .i_nRst(nRst), .i_hsel(hsel), .i_haddr(haddr),
      .i_htrans(htrans), .i_hsize(hsize), .i_hwrite(hwrite), .i_hwdata(hwdata),
      .o_hrdata(hrdata), .o_hready(hready), .o_hresp(hresp),
      .i_statusData(statusData), .i_errorData(errorData), .i_boData(boData),
      .i_ehtsData(ehtsData), .o_nextEHTSData(nextEHTSData),
      .o_clearError(clearError), .o_flush(flush), .o_bufRead(bufRead),
      .o_bufWrite(bufWrite), .o_bufSize(bufSize), .o_bufWdata(bufWdata),
      .i_bufRdata(bufRdata), .i_bufAck(bufAck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: one outstanding data phase ----------
   bit         m_busy;
   int         m_age;     // data-phase cycles already spent
   int         m_kind;
   logic [3:0] m_addr;
   logic       m_write;
   logic [1:0] m_size;

   function automatic int classify(input logic [3:0] a, input logic w, input logic [1:0] sz);
      if (sz == 2'b11)            return K_ERR;
      if (a < 4'h4)               return K_BUF;
      if (a == 4'h4 || a == 4'h8) return w ? K_ERR : K_REG;
      if (a == 4'h6 || a == 4'hC || a == 4'hD) return K_REG;
      return K_ERR;
   endfunction

   function automatic logic [31:0] reg_field(input logic [3:0] a);
      case (a)
         4'h4:    return {16'h0, statusData};
         4'h6:    return {16'h0, errorData};
         4'h8:    return {24'h0, boData};
         4'hC:    return {24'h0, ehtsData};
         default: return 32'h0;
      endcase
   endfunction

   // Error transfers last two cycles; a buffer transfer gets T request cycles
   // and then the same two error cycles.
   function automatic logic exp_ready();
      if (!m_busy) return 1'b1;
      case (m_kind)
         K_REG:   return 1'b1;
         K_ERR:   return (m_age == 1);
         default: return (m_age < T) ? bufAck : (m_age == T + 1);
      endcase
   endfunction

   function automatic logic exp_resp();
      if (!m_busy)          return 1'b0;
      if (m_kind == K_ERR)  return 1'b1;
      if (m_kind == K_BUF)  return (m_age >= T);
      return 1'b0;
   endfunction

   always @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         m_busy <= 1'b0; m_age <= 0; m_kind <= K_REG;
         m_addr <= 4'h0; m_write <= 1'b0; m_size <= 2'b00;
      end else if (m_busy && !exp_ready()) begin
         m_age <= m_age + 1;
      end else if ((!m_busy || !exp_resp()) && hsel && htrans[1]) begin
         m_busy  <= 1'b1;
         m_age   <= 0;
         m_addr  <= haddr;
         m_write <= hwrite;
         m_size  <= hsize;
         m_kind  <= classify(haddr, hwrite, hsize);
      end else begin
         m_busy <= 1'b0;
         m_age  <= 0;
      end
   end

   task automatic compare_cycle();
      logic [31:0] e_rdata;
      logic        e_clr, e_fl, e_rd, e_wr;
      logic [7:0]  e_next;
      e_rdata = 32'h0; e_clr = 1'b0; e_fl = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
      e_next  = ehtsData;
      if (m_busy && m_kind == K_REG) begin
         if (m_write) begin
            if (m_addr == 4'h6) e_clr  = 1'b1;
            if (m_addr == 4'hD) e_fl   = hwdata[0];
            if (m_addr == 4'hC) e_next = hwdata[7:0];
         end else begin
            e_rdata = reg_field(m_addr) << (8 * m_addr[1:0]);
         end
      end
      if (m_busy && m_kind == K_BUF && m_age < T) begin
         if (bufAck) begin
            if (!m_write) e_rdata = bufRdata;
         end else begin
            e_rd = !m_write;
            e_wr = m_write;
         end
      end
      chk("m_hready",   32'(hready),       32'(exp_ready()));
      chk("m_hresp",    32'(hresp),        32'(exp_resp()));
      chk("m_hrdata",   hrdata,            e_rdata);
      chk("m_clrErr",   32'(clearError),   32'(e_clr));
      chk("m_flush",    32'(flush),        32'(e_fl));
      chk("m_bufRead",  32'(bufRead),      32'(e_rd));
      chk("m_bufWrite", 32'(bufWrite),     32'(e_wr));
      chk("m_nextEHTS", 32'(nextEHTSData), 32'(e_next));
      chk("m_bufSize",  32'(bufSize),      32'(m_size));
      chk("m_bufWdata", bufWdata,          hwdata);
   endtask

   always @(negedge clk) if (chk_en) compare_cycle();

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic addr_ph(input logic [3:0] a, input logic w, input logic [1:0] sz);
      hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = w; hsize = sz;
   endtask

   task automatic bus_idle();
      hsel = 1'b0; haddr = 4'h0; htrans = 2'b00; hwrite = 1'b0; hsize = 2'b00;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      nRst = 1'b0; bus_idle(); hwdata = 32'h0; bufAck = 1'b0; bufRdata = 32'h0;
      statusData = 16'h0301; errorData = 16'hBEEF; boData = 8'h05; ehtsData = 8'h5A;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_hready",  32'(hready),       32'h1);
      chk("rst_hresp",   32'(hresp),        32'h0);
      chk("rst_hrdata",  hrdata,            32'h0);
      chk("rst_bufRead", 32'(bufRead),      32'h0);
      chk("rst_bufSize", 32'(bufSize),      32'h0);
      chk("rst_next",    32'(nextEHTSData), 32'h5A);
      chk_en = 1;
      tick(); nRst = 1'b1;

      // Status read, half-word
      tick(); addr_ph(4'h4, 1'b0, 2'b01);
      tick(); bus_idle();
      @(negedge clk);
      chk("rd_status", hrdata, 32'h0000_0301);
      chk("rd_status_ready", 32'(hready), 32'h1);

      // EHTS write then fall back to ehtsData
      tick(); addr_ph(4'hC, 1'b1, 2'b00);
      tick(); bus_idle(); hwdata = 32'h0000_0040;
      @(negedge clk); chk("ehts_wr", 32'(nextEHTSData), 32'h40);
      tick();
      @(negedge clk); chk("ehts_after", 32'(nextEHTSData), 32'h5A);

      // Back-to-back occupancy reads
      tick(); addr_ph(4'h8, 1'b0, 2'b00); boData = 8'h05;
      tick(); addr_ph(4'h8, 1'b0, 2'b00);
      @(negedge clk); chk("bo_rd1", hrdata, 32'h05);
      tick(); bus_idle(); boData = 8'h06;
      @(negedge clk); chk("bo_rd2", hrdata, 32'h06);

      // Buffer word read acknowledged on the fourth data-phase cycle
      tick(); addr_ph(4'h0, 1'b0, 2'b10);
      tick(); bus_idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("buf_rd_req", 32'(bufRead), 32'h1);
         chk("buf_rd_wait", 32'(hready), 32'h0);
         tick();
      end
      bufAck = 1'b1; bufRdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("buf_rd_data", hrdata, 32'hDEAD_BEEF);
      chk("buf_rd_ready", 32'(hready), 32'h1);
      chk("buf_rd_drop", 32'(bufRead), 32'h0);
      tick(); bufAck = 1'b0; bufRdata = 32'h0;

      // Write to read-only occupancy, then unmapped read
      tick(); addr_ph(4'h8, 1'b1, 2'b00);
      tick(); bus_idle(); hwdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("err_wr8_c1", {30'h0, hready, hresp}, 32'h1);
      chk("err_wr8_fl", 32'(flush), 32'h0);
      tick();
      @(negedge clk); chk("err_wr8_c2", {30'h0, hready, hresp}, 32'h3);
      tick(); addr_ph(4'h9, 1'b0, 2'b00);
      tick(); bus_idle(); hwdata = 32'h0;
      @(negedge clk); chk("err_rd9_c1", {30'h0, hready, hresp}, 32'h1);
      tick();
      @(negedge clk); chk("err_rd9_c2", {30'h0, hready, hresp}, 32'h3);

      // Buffer write timeout
      tick(); addr_ph(4'h0, 1'b1, 2'b10);
      tick(); bus_idle(); hwdata = 32'hCAFE_F00D;
      for (int i = 0; i < T; i++) begin
         @(negedge clk); chk("to_req", 32'(bufWrite), 32'h1);
         tick();
      end
      @(negedge clk);
      chk("to_drop", 32'(bufWrite), 32'h0);
      chk("to_err_c1", {30'h0, hready, hresp}, 32'h1);
      tick();
      @(negedge clk); chk("to_err_c2", {30'h0, hready, hresp}, 32'h3);

      // Acknowledge on the last allowed cycle wins
      tick(); addr_ph(4'h0, 1'b1, 2'b10);
      tick(); bus_idle();
      for (int i = 0; i < T - 1; i++) tick();
      bufAck = 1'b1;
      @(negedge clk);
      chk("late_ack", {30'h0, hready, hresp}, 32'h2);
      tick(); bufAck = 1'b0;
      @(negedge clk); chk("late_ack_idle", {30'h0, hready, hresp}, 32'h2);

      // Flush then clear-error, pipelined
      tick(); addr_ph(4'hD, 1'b1, 2'b00);
      tick(); addr_ph(4'h6, 1'b1, 2'b01); hwdata = 32'h1;
      @(negedge clk); chk("flush_pulse", {30'h0, flush, clearError}, 32'h2);
      tick(); bus_idle(); hwdata = 32'h0;
      @(negedge clk); chk("clr_pulse", {30'h0, flush, clearError}, 32'h1);
      tick();
      @(negedge clk); chk("pulses_off", {30'h0, flush, clearError}, 32'h0);
      tick(); addr_ph(4'hD, 1'b1, 2'b00);
      tick(); bus_idle(); hwdata = 32'hFFFF_FFFE;
      @(negedge clk); chk("flush_zero", 32'(flush), 32'h0);

      // IDLE and BUSY transfers to an unmapped address are harmless
      tick(); hsel = 1'b1; haddr = 4'h9; htrans = 2'b00;
      tick(); htrans = 2'b01;
      @(negedge clk); chk("idle_xfer", {30'h0, hready, hresp}, 32'h2);
      tick(); bus_idle();
      @(negedge clk); chk("busy_xfer", {30'h0, hready, hresp}, 32'h2);

      // Illegal size
      tick(); addr_ph(4'h4, 1'b0, 2'b11);
      tick(); bus_idle();
      @(negedge clk); chk("size_err_c1", {30'h0, hready, hresp}, 32'h1);
      tick();
      @(negedge clk); chk("size_err_c2", {30'h0, hready, hresp}, 32'h3);

      // Lane placement: error, EHTS, flush (write-only) reads
      tick(); addr_ph(4'h6, 1'b0, 2'b01);
      tick(); addr_ph(4'hC, 1'b0, 2'b00);
      @(negedge clk); chk("rd_error", hrdata, 32'hBEEF_0000);
      tick(); addr_ph(4'hD, 1'b0, 2'b00);
      @(negedge clk); chk("rd_ehts", hrdata, 32'h0000_005A);
      tick(); bus_idle();
      @(negedge clk); chk("rd_flush", hrdata, 32'h0);

      // Stray acknowledge outside a buffer access
      tick(); bufAck = 1'b1; bufRdata = 32'h1234_5678;
      @(negedge clk); chk("stray_ack", hrdata, 32'h0);
      tick(); bufAck = 1'b0; bufRdata = 32'h0;

      // Asynchronous reset in the middle of a buffer wait
      tick(); addr_ph(4'h0, 1'b0, 2'b10);
      tick(); bus_idle();
      #2;
      chk("pre_rst_req", 32'(bufRead), 32'h1);
      nRst = 1'b0;
      #1;
      chk("async_rst_req", 32'(bufRead), 32'h0);
      chk("async_rst_ready", 32'(hready), 32'h1);
      tick(); tick(); nRst = 1'b1;
      tick(); addr_ph(4'h4, 1'b0, 2'b01);
      tick(); bus_idle();
      @(negedge clk); chk("post_rst_rd", hrdata, 32'h0000_0301);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
